// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED frame path (text engine writer and SPI streamer).
package oled_pkg;

  localparam int NUM_PAGES_DEF = 8;
  localparam int NUM_COLS_DEF  = 128;
  localparam int ADDR_W        = 14;

  localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO   = 8'h00;
  localparam logic [7:0] CMD_COL_HI   = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_RAM_REQ  = 3'd2,
    ST_RAM_WAIT = 3'd3,
    ST_SHIFT    = 3'd4,
    ST_NEXT     = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [7:0] page);
    case (idx)
      2'd0:    cmd_byte = CMD_SET_PAGE | page;
      2'd1:    cmd_byte = CMD_COL_LO;
      default: cmd_byte = CMD_COL_HI;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Mode-0 SPI byte shifter: MSB first, SCLK idles low, done pulses during the last cycle of the byte.
module spi_byte_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       done_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic          active_q, active_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    half_q, half_d;
  logic [7:0]    shift_q, shift_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          done_q, done_d;

  // Next-state for the half-period divider and bit shifter; odd halves are SCLK high.
  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    half_d   = half_q;
    shift_d  = shift_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    if (load_i) begin
      active_d = 1'b1;
      div_d    = {DW{1'b0}};
      half_d   = 4'd0;
      shift_d  = {byte_i[6:0], 1'b0};
      mosi_d   = byte_i[7];
      sclk_d   = 1'b0;
    end else if (active_q && (div_q == DIV_MAX)) begin
      div_d = {DW{1'b0}};
      if (half_q == 4'd15) begin
        active_d = 1'b0;
        half_d   = 4'd0;
        sclk_d   = 1'b0;
      end else if (half_q[0] == 1'b0) begin
        half_d = half_q + 4'd1;
        sclk_d = 1'b1;
      end else begin
        half_d  = half_q + 4'd1;
        sclk_d  = 1'b0;
        mosi_d  = shift_q[7];
        shift_d = {shift_q[6:0], 1'b0};
      end
    end else if (active_q) begin
      div_d = div_q + DW'(1);
    end else begin
      active_d = 1'b0;
    end
    done_d = active_d && (half_d == 4'd15) && (div_d == DIV_MAX);
  end

  // Shifter state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      div_q    <= {DW{1'b0}};
      half_q   <= 4'd0;
      shift_q  <= 8'h00;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      half_q   <= half_d;
      shift_q  <= shift_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign done_o = done_q;

endmodule

// File: rtl/oled_frame_streamer.sv
// Streams the page-organised frame buffer to an SSD1306-class OLED: per page a 3-byte
// address command followed by NUM_COLS data bytes, one frame per start pulse.
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int NUM_PAGES = NUM_PAGES_DEF,
  parameter int NUM_COLS  = NUM_COLS_DEF
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [ADDR_W-1:0] o_ram_address,
  input  logic [7:0]        i_ram_data,
  output logic              o_spi_sclk,
  output logic              o_spi_mosi,
  output logic              o_spi_cs_n,
  output logic              o_spi_dc
);

  localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [PW-1:0] PAGE_LAST = PW'(NUM_PAGES - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(NUM_COLS - 1);
  // cmd_idx 0..2 walks the page header; 3 marks the data phase of the page.
  localparam logic [1:0]    DATA_PHASE = 2'd3;

  state_t            state_q, state_d;
  logic [PW-1:0]     page_q, page_d;
  logic [CW-1:0]     col_q, col_d;
  logic [1:0]        cmd_idx_q, cmd_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_n_q, cs_n_d;
  logic              dc_q, dc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_base_s;
  logic              tx_load_s;
  logic [7:0]        tx_byte_s;
  logic              tx_done_s;

  assign row_base_s = ADDR_W'(page_q) * ADDR_W'(NUM_COLS);

  // Frame sequencer: next state, counters and registered SPI framing signals.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    col_d     = col_q;
    cmd_idx_d = cmd_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_n_d    = cs_n_q;
    dc_d      = dc_q;
    addr_d    = addr_q;
    tx_load_s = 1'b0;
    tx_byte_s = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_CMD;
          page_d    = {PW{1'b0}};
          col_d     = {CW{1'b0}};
          cmd_idx_d = 2'd0;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        tx_load_s = 1'b1;
        tx_byte_s = cmd_byte(cmd_idx_q, 8'(page_q));
        dc_d      = 1'b0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tx_done_s) begin
          state_d = ST_NEXT;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_RAM_REQ: begin
        state_d = ST_RAM_WAIT;
      end
      ST_RAM_WAIT: begin
        tx_load_s = 1'b1;
        tx_byte_s = i_ram_data;
        dc_d      = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_NEXT: begin
        if (cmd_idx_q < 2'd2) begin
          cmd_idx_d = cmd_idx_q + 2'd1;
          state_d   = ST_CMD;
        end else if (cmd_idx_q == 2'd2) begin
          cmd_idx_d = DATA_PHASE;
          col_d     = {CW{1'b0}};
          addr_d    = row_base_s;
          state_d   = ST_RAM_REQ;
        end else if (col_q != COL_LAST) begin
          col_d   = col_q + CW'(1);
          addr_d  = row_base_s + ADDR_W'(col_d);
          state_d = ST_RAM_REQ;
        end else if (page_q != PAGE_LAST) begin
          page_d    = page_q + PW'(1);
          cmd_idx_d = 2'd0;
          state_d   = ST_CMD;
        end else begin
          cs_n_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      page_q    <= {PW{1'b0}};
      col_q     <= {CW{1'b0}};
      cmd_idx_q <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      dc_q      <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      col_q     <= col_d;
      cmd_idx_q <= cmd_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
      dc_q      <= dc_d;
      addr_q    <= addr_d;
    end
  end

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk_i  (clk),
    .rst_ni (i_rst_n),
    .load_i (tx_load_s),
    .byte_i (tx_byte_s),
    .sclk_o (o_spi_sclk),
    .mosi_o (o_spi_mosi),
    .done_o (tx_done_s)
  );

  assign o_busy        = busy_q;
  assign o_frame_done  = done_q;
  assign o_ram_address = addr_q;
  assign o_spi_cs_n    = cs_n_q;
  assign o_spi_dc      = dc_q;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Bench for oled_frame_streamer: byte-stream scoreboard on a CLK_DIV=2 full-size instance,
// plus two small instances (CLK_DIV=1 and 7) for SCLK widths and frame latency.
`timescale 1ns/1ps
module tb_oled_frame_streamer;

  localparam int D_MAIN      = 2;
  localparam int NP          = 8;
  localparam int NC          = 128;
  localparam int FRAME_BYTES = NP * (3 + NC);
  localparam int SP          = 2;
  localparam int SC          = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic        busy, fdone, sclk, mosi, cs_n, dc;
  logic [13:0] addr;
  logic [7:0]  ram_data;

  logic        s_start;
  logic [1:0]  s_busy, s_fdone, s_sclk, s_mosi, s_cs_n, s_dc;
  logic [13:0] s_addr [2];
  logic [7:0]  s_ram [2];

  oled_frame_streamer #(.CLK_DIV(D_MAIN), .NUM_PAGES(NP), .NUM_COLS(NC)) u_dut (
    .clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_frame_done(fdone),
    .o_ram_address(addr), .i_ram_data(ram_data), .o_spi_sclk(sclk), .o_spi_mosi(mosi),
    .o_spi_cs_n(cs_n), .o_spi_dc(dc));

  oled_frame_streamer #(.CLK_DIV(1), .NUM_PAGES(SP), .NUM_COLS(SC)) u_d1 (
    .clk(clk), .i_rst_n(rst_n), .i_start(s_start), .o_busy(s_busy[0]), .o_frame_done(s_fdone[0]),
    .o_ram_address(s_addr[0]), .i_ram_data(s_ram[0]), .o_spi_sclk(s_sclk[0]), .o_spi_mosi(s_mosi[0]),
    .o_spi_cs_n(s_cs_n[0]), .o_spi_dc(s_dc[0]));

  oled_frame_streamer #(.CLK_DIV(7), .NUM_PAGES(SP), .NUM_COLS(SC)) u_d7 (
    .clk(clk), .i_rst_n(rst_n), .i_start(s_start), .o_busy(s_busy[1]), .o_frame_done(s_fdone[1]),
    .o_ram_address(s_addr[1]), .i_ram_data(s_ram[1]), .o_spi_sclk(s_sclk[1]), .o_spi_mosi(s_mosi[1]),
    .o_spi_cs_n(s_cs_n[1]), .o_spi_dc(s_dc[1]));

  // Frame buffer models: one-cycle read latency, contents = address & 0xFF.
  always @(posedge clk) begin
    ram_data <= addr[7:0];
    s_ram[0] <= s_addr[0][7:0];
    s_ram[1] <= s_addr[1][7:0];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat_exp(input int d, input int p, input int n);
    return p * 3 * (16 * d + 2) + p * n * (16 * d + 3) + 2;
  endfunction

  // Expected byte stream, {dc, byte}.
  logic [8:0] exp_q[$];
  logic [7:0] rx_log [FRAME_BYTES];
  int         rx_cnt = 0;
  int         done_cnt = 0;
  int         bit_cnt = 0;
  logic [7:0] sh = 8'h00;
  logic       dc_byte = 1'b0;
  logic       p_sclk = 1'b0, p_mosi = 1'b0, p_dc = 1'b0, p_cs_n = 1'b1;

  int   s_hi [2] = '{0, 0};
  int   s_lo [2] = '{0, 0};
  int   s_bit [2] = '{0, 0};
  int   s_rise [2] = '{0, 0};
  logic [1:0] s_psclk = 2'b00;
  int   sdiv [2] = '{1, 7};

  task automatic push_frame();
    for (int p = 0; p < NP; p++) begin
      exp_q.push_back({1'b0, 8'hB0 + 8'(p)});
      exp_q.push_back(9'h000);
      exp_q.push_back(9'h010);
      for (int c = 0; c < NC; c++) exp_q.push_back({1'b1, 8'((p * NC + c) % 256)});
    end
  endtask

  // Compare process: SPI decoder/scoreboard for the main instance, SCLK widths for the small ones.
  always @(negedge clk) begin
    logic [7:0] sh_n;
    logic [8:0] e;
    if (!rst_n) begin
      exp_q.delete();
      bit_cnt = 0;
      rx_cnt  = 0;
      for (int k = 0; k < 2; k++) begin
        s_hi[k] = 0; s_lo[k] = 0; s_bit[k] = 0;
      end
    end else begin
      if (fdone) done_cnt++;
      if (sclk) check("stable_while_sclk_high", {29'd0, mosi, dc, cs_n}, {29'd0, p_mosi, p_dc, p_cs_n});
      if (sclk && !p_sclk) begin
        check("cs_low_at_rise", {31'd0, cs_n}, 32'd0);
        sh_n = {sh[6:0], mosi};
        sh = sh_n;
        if (bit_cnt == 0) dc_byte = dc;
        else check("dc_constant_in_byte", {31'd0, dc}, {31'd0, dc_byte});
        bit_cnt++;
        if (bit_cnt == 8) begin
          bit_cnt = 0;
          check("exp_queue_nonempty", {31'd0, (exp_q.size() > 0)}, 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("byte%0d_dc_data", rx_cnt), {23'd0, dc_byte, sh_n}, {23'd0, e});
          end
          if (rx_cnt < FRAME_BYTES) rx_log[rx_cnt] = sh_n;
          rx_cnt++;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (s_sclk[k] != s_psclk[k]) begin
          if (s_sclk[k]) begin
            if (s_bit[k] != 0) check($sformatf("sclk_low_width_k%0d", k), s_lo[k], sdiv[k]);
            else check($sformatf("sclk_first_low_ge_k%0d", k), {31'd0, (s_lo[k] >= sdiv[k])}, 32'd1);
            s_bit[k] = (s_bit[k] + 1) % 8;
            s_rise[k]++;
          end else begin
            check($sformatf("sclk_high_width_k%0d", k), s_hi[k], sdiv[k]);
          end
          s_hi[k] = 0;
          s_lo[k] = 0;
        end
        if (s_sclk[k]) s_hi[k]++;
        else s_lo[k]++;
      end
    end
    p_sclk = sclk; p_mosi = mosi; p_dc = dc; p_cs_n = cs_n;
    s_psclk = s_sclk;
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  {31'd0, busy},  32'd0);
    check({tag, "_fdone"}, {31'd0, fdone}, 32'd0);
    check({tag, "_addr"},  {18'd0, addr},  32'd0);
    check({tag, "_sclk"},  {31'd0, sclk},  32'd0);
    check({tag, "_mosi"},  {31'd0, mosi},  32'd0);
    check({tag, "_cs_n"},  {31'd0, cs_n},  32'd1);
    check({tag, "_dc"},    {31'd0, dc},    32'd0);
  endtask

  initial begin
    int s_lat [2];
    int cyc, busy_drop, done_before, got;
    rst_n = 1'b0; start = 1'b0; s_start = 1'b0;
    s_lat = '{0, 0};
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Small instances: latency formula and SCLK widths at CLK_DIV=1 and 7.
    s_start = 1'b1;
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      s_start = 1'b0;
      cyc++;
      for (int k = 0; k < 2; k++) if (s_fdone[k] && s_lat[k] == 0) s_lat[k] = cyc;
      if (s_lat[0] != 0 && s_lat[1] != 0) break;
    end
    check("lat_d1_model", s_lat[0], lat_exp(1, SP, SC));
    check("lat_d7_model", s_lat[1], lat_exp(7, SP, SC));
    check("lat_d1_literal", s_lat[0], 32'd262);
    check("lat_d7_literal", s_lat[1], 32'd1606);
    check("rises_d1", s_rise[0], 8 * SP * (3 + SC));
    check("rises_d7", s_rise[1], 8 * SP * (3 + SC));
    repeat (5) @(negedge clk);

    // Frame A: abandoned by reset mid-byte in page 3.
    push_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (rx_cnt >= 3 * (3 + NC) + 5 && sclk) begin got = 1; break; end
    end
    check("reached_page3_mid_byte", got, 32'd1);
    done_before = done_cnt;
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", done_cnt, done_before);
    check("idle_after_abort_busy", {31'd0, busy}, 32'd0);

    // Frame B: complete frame, with a second start 100 cycles in that must be ignored.
    rx_cnt = 0;
    push_frame();
    done_before = done_cnt;
    start = 1'b1;
    cyc = 0; busy_drop = 0; got = 0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 100);
      if (fdone) begin got = 1; break; end
      else if (!busy) busy_drop++;
    end
    check("frameB_done_seen", got, 32'd1);
    check("frameB_latency_model", cyc, lat_exp(D_MAIN, NP, NC));
    check("frameB_latency_literal", cyc, 32'd36658);
    check("frameB_busy_continuous", busy_drop, 32'd0);
    check("frameB_busy_low_with_done", {31'd0, busy}, 32'd0);
    check("frameB_cs_high_at_done", {31'd0, cs_n}, 32'd1);
    check("frameB_byte_count", rx_cnt, FRAME_BYTES);
    check("frameB_queue_drained", exp_q.size(), 32'd0);
    check("lit_p0_hdr0", {24'd0, rx_log[0]}, 32'hB0);
    check("lit_p0_hdr1", {24'd0, rx_log[1]}, 32'h00);
    check("lit_p0_hdr2", {24'd0, rx_log[2]}, 32'h10);
    check("lit_p0_d0",   {24'd0, rx_log[3]}, 32'h00);
    check("lit_p0_d127", {24'd0, rx_log[130]}, 32'h7F);
    check("lit_p7_hdr0", {24'd0, rx_log[917]}, 32'hB7);
    check("lit_p7_d0",   {24'd0, rx_log[920]}, 32'h80);
    check("lit_p7_d127", {24'd0, rx_log[1047]}, 32'hFF);

    // Frame C: start in the cycle after frame_done.
    @(negedge clk);
    check("done_single_pulse", {31'd0, fdone}, 32'd0);
    check("done_count_one", done_cnt, done_before + 1);
    check("cs_high_between_frames", {31'd0, cs_n}, 32'd1);
    rx_cnt = 0;
    push_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accepted_busy", {31'd0, busy}, 32'd1);
    check("b2b_cs_low", {31'd0, cs_n}, 32'd0);
    repeat (300) @(negedge clk);
    check("b2b_bytes_flowing", {31'd0, (rx_cnt >= 3)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oled_frame_streamer.md
# oled_frame_streamer

Downstream of the text engine: scans the 1024-byte page-organised frame buffer that the text engine writes and streams it to an SSD1306-class 128x64 OLED over 4-wire SPI (SCLK, MOSI, CS_n, D/C). Each frame is sent page by page. Each page is a 3-byte page/column address command followed by 128 data bytes read from the buffer's read port. One frame is triggered per start pulse.

## Interface
- CLK_DIV, 4, clk cycles per SCLK half-period; must be ≥1
- NUM_PAGES, 8, display pages per frame
- NUM_COLS, 128, bytes per page
- clk  input  1  system clock, all logic on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle pulse; begins a frame when idle
- o_busy  output  1  high from the cycle after an accepted i_start until o_frame_done
- o_frame_done  output  1  one-cycle pulse after the last bit of the frame
- o_ram_address  output  14  frame buffer read address, page*NUM_COLS + column
- i_ram_data  input  8  read data; valid exactly 1 cycle after o_ram_address is presented
- o_spi_sclk  output  1  SPI clock, mode 0, idles low
- o_spi_mosi  output  1  serial data, MSB first
- o_spi_cs_n  output  1  chip select, low for the whole frame
- o_spi_dc  output  1  0 = command byte, 1 = data byte

## Operation
- Reset values: o_busy 0, o_frame_done 0, o_ram_address 0, o_spi_sclk 0, o_spi_mosi 0, o_spi_cs_n 1, o_spi_dc 0. Reset clears the FSM from any state, including mid-byte; the partial frame is abandoned with no completion pulse.
- States:
  - IDLE: waits for i_start. When i_start is seen, goes to CMD with page=0, cmd_idx=0, and drives CS_n low.
  - CMD: loads the command byte and sets DC=0, then goes to SHIFT.
    - cmd_idx 0 sends 0xB0|page.
    - cmd_idx 1 sends 0x00 (column low nibble).
    - cmd_idx 2 sends 0x10 (column high nibble).
  - RAM_REQ: presents address page*NUM_COLS+col.
  - RAM_WAIT: captures i_ram_data into the shift register, sets DC=1, then goes to SHIFT.
  - SHIFT: sends 8 bits.
  - NEXT: chooses the next step.
    - cmd_idx<2 → cmd_idx+1, go to CMD.
    - cmd_idx==2 → go to RAM_REQ with col=0.
    - col<NUM_COLS-1 → col+1, go to RAM_REQ.
    - col==NUM_COLS-1 and page<NUM_PAGES-1 → page+1, cmd_idx=0, go to CMD.
    - Otherwise → DONE.
  - DONE: CS_n high, o_frame_done pulses for 1 cycle, o_busy drops in the same cycle, returns to IDLE.
- i_start while busy is ignored; it is not queued.
- Frame contents: NUM_PAGES*(3+NUM_COLS) bytes, which is 1048 at defaults.
- Counter widths:
  - col: clog2(NUM_COLS).
  - page: clog2(NUM_PAGES).
  - The address product is computed in 14 bits. No wrap within a frame, since 1023 < 2^14.
- The frame buffer is never written by this block and there is no ordering guarantee against concurrent text engine writes. A byte read mid-update shows either the old or the new value.

## Timing
- Bit shifting (mode 0):
  - MOSI is set while SCLK is low and held for the full bit.
  - SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - 8 bits take 16*CLK_DIV cycles. SCLK returns low at the end of the byte.
- D/C changes only while SCLK is low, at least CLK_DIV cycles before the first rising edge of its byte.
- Byte slot lengths (load cycles plus shift):
  - Command byte: 1 (CMD) + 16*CLK_DIV + 1 (NEXT).
  - Data byte: 2 (RAM_REQ, RAM_WAIT) + 16*CLK_DIV + 1 (NEXT).
- CS_n falls 1 cycle after i_start is accepted, which is at least CLK_DIV cycles before the first SCLK rise. CS_n rises in DONE.
- Frame latency from i_start to o_frame_done is deterministic. At CLK_DIV=4 it is 24*(16*4+2) + 1024*(16*4+3) + 2 cycles.

## Structure
- Shared package oled_pkg holds:
  - The state enum.
  - Command constants CMD_SET_PAGE=8'hB0, CMD_COL_LO=8'h00, CMD_COL_HI=8'h10.
  - Defaults for NUM_PAGES and NUM_COLS, also used by the text engine's address math.
- Sub-module spi_byte_tx:
  - Inputs: load pulse and 8-bit byte. Outputs: sclk, mosi, and a one-cycle done pulse.
  - Parameter: CLK_DIV.
  - The top FSM owns CS_n, D/C and RAM addressing.

## Test plan
- CLK_DIV=2, RAM model with 1-cycle latency holding address&8'hFF, i_start pulse → SPI monitor decodes 1048 bytes:
  - Page 0 header B0 00 10, then data 00..7F.
  - Page 7 header B7 00 10, then data 80..FF (addresses 896..1023).
  - o_frame_done pulses exactly once.
- D/C check on the same run: DC=0 on every command byte and DC=1 on every data byte, sampled at each SCLK rise. No DC, MOSI or CS_n transition occurs while SCLK is high.
- i_start pulsed again 100 cycles into a frame → ignored; byte count stays 1048; o_busy stays high continuously.
- i_rst_n asserted mid-byte in page 3 → in the same cycle all outputs take reset values with CS_n=1 and SCLK=0. No o_frame_done pulse. A later i_start produces a complete, correct frame.
- CLK_DIV=1 and CLK_DIV=7 → SCLK high and low widths each equal CLK_DIV, and total frame cycle count matches the formula.
- Back-to-back: i_start in the cycle after o_frame_done → new frame accepted; CS_n high for at least 1 cycle between frames.
